// File: rtl/pulse_discriminator_if.sv
// Sample stream, discriminator configuration and trigger/ToT results for pulse_discriminator.
// master = upstream sample source / configuration owner, slave = the discriminator.
interface pulse_discriminator_if #(
  parameter int DATA_W = 12,
  parameter int TOT_W  = 16
);
  logic [DATA_W-1:0] ADC_DATA;
  logic              ADC_VALID;
  logic              ENABLE;
  logic [DATA_W-1:0] THRESHOLD;
  logic [DATA_W-1:0] HYSTERESIS;
  logic [TOT_W-1:0]  TOT_MIN;
  logic              EDGE_TRIGGER;
  logic              TOT_TRIGGER;
  logic [TOT_W-1:0]  TOT_LENGTH;
  logic              TOT_VALID;
  logic [DATA_W-1:0] BASELINE;
  logic              PULSE_ACTIVE;

  modport master (
    output ADC_DATA, ADC_VALID, ENABLE, THRESHOLD, HYSTERESIS, TOT_MIN,
    input  EDGE_TRIGGER, TOT_TRIGGER, TOT_LENGTH, TOT_VALID, BASELINE, PULSE_ACTIVE
  );

  modport slave (
    input  ADC_DATA, ADC_VALID, ENABLE, THRESHOLD, HYSTERESIS, TOT_MIN,
    output EDGE_TRIGGER, TOT_TRIGGER, TOT_LENGTH, TOT_VALID, BASELINE, PULSE_ACTIVE
  );
endinterface

// File: rtl/pulse_discriminator.sv
// Baseline-tracking threshold discriminator with hysteresis, ToT measurement and post-pulse hold.
// Define NEG_POLARITY_EN to detect negative-going pulses (amplitude = baseline - sample).
module pulse_discriminator #(
  parameter int DATA_W       = 12,
  parameter int BASE_SHIFT   = 4,
  parameter int TOT_W        = 16,
  parameter int HOLD_SAMPLES = 8
) (
  input  logic CLK,
  input  logic RESET_N,
  pulse_discriminator_if.slave bus
);
  localparam int ACC_W  = DATA_W + BASE_SHIFT;
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 2);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_SAMPLES);

  typedef enum logic [1:0] {IDLE, HIGH, HOLD} state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic                loaded;
  logic [TOT_W-1:0]    tot_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                edge_q, tot_trig_q, tot_vld_q;
  logic [TOT_W-1:0]    tot_len_q;

  logic [DATA_W-1:0]   base, amp, rel;
  logic signed [DATA_W:0] diff;
  logic [ACC_W-1:0]    acc_next, acc_preload;

  assign base = acc[ACC_W-1:BASE_SHIFT];

`ifdef NEG_POLARITY_EN
  assign diff = $signed({1'b0, base}) - $signed({1'b0, bus.ADC_DATA});
`else
  assign diff = $signed({1'b0, bus.ADC_DATA}) - $signed({1'b0, base});
`endif

  assign amp = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
  assign rel = (bus.THRESHOLD >= bus.HYSTERESIS) ? (bus.THRESHOLD - bus.HYSTERESIS) : '0;

  // Modular wrap of acc + sample is harmless: the final sum always fits ACC_W.
  assign acc_next    = acc + ACC_W'(bus.ADC_DATA) - ACC_W'(base);
  assign acc_preload = ACC_W'(bus.ADC_DATA) << BASE_SHIFT;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      acc        <= '0;
      loaded     <= 1'b0;
      tot_cnt    <= '0;
      hold_cnt   <= '0;
      edge_q     <= 1'b0;
      tot_trig_q <= 1'b0;
      tot_vld_q  <= 1'b0;
      tot_len_q  <= '0;
    end else begin
      edge_q     <= 1'b0;
      tot_trig_q <= 1'b0;
      tot_vld_q  <= 1'b0;
      if (bus.ADC_VALID && !loaded) begin
        acc    <= acc_preload;
        loaded <= 1'b1;
      end else if (!bus.ENABLE) begin
        // Disarm discards any pulse in flight; baseline keeps following the input in IDLE.
        state    <= IDLE;
        tot_cnt  <= '0;
        hold_cnt <= '0;
        if (bus.ADC_VALID && state == IDLE) acc <= acc_next;
      end else if (bus.ADC_VALID) begin
        unique case (state)
          IDLE: begin
            if (amp >= bus.THRESHOLD) begin
              edge_q  <= 1'b1;
              tot_cnt <= TOT_W'(1);
              state   <= HIGH;
            end else begin
              acc <= acc_next;
            end
          end
          HIGH: begin
            if (amp >= rel) begin
              if (tot_cnt != '1) tot_cnt <= tot_cnt + TOT_W'(1);
            end else begin
              tot_len_q  <= tot_cnt;
              tot_vld_q  <= 1'b1;
              tot_trig_q <= (tot_cnt >= bus.TOT_MIN);
              hold_cnt   <= HOLD_INIT;
              state      <= (HOLD_SAMPLES == 0) ? IDLE : HOLD;
            end
          end
          HOLD: begin
            if (hold_cnt <= HOLD_W'(1)) begin
              hold_cnt <= '0;
              state    <= IDLE;
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.EDGE_TRIGGER = edge_q;
  assign bus.TOT_TRIGGER  = tot_trig_q;
  assign bus.TOT_VALID    = tot_vld_q;
  assign bus.TOT_LENGTH   = tot_len_q;
  assign bus.BASELINE     = base;
  assign bus.PULSE_ACTIVE = (state == HIGH);
endmodule

// File: tb/tb_pulse_discriminator.sv
// Directed and randomized checks of pulse_discriminator against an integer reference model.
// Narrow ToT width so counter saturation is reachable in a short run.
module tb_pulse_discriminator;
  localparam int DW   = 12;
  localparam int TW   = 6;
  localparam int HOLD = 8;
  localparam int TOT_MAX = (1 << TW) - 1;
`ifdef NEG_POLARITY_EN
  localparam int POL = -1;
`else
  localparam int POL = 1;
`endif

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int checks = 0;
  int errors = 0;

  pulse_discriminator_if #(.DATA_W(DW), .TOT_W(TW)) bus ();

  pulse_discriminator #(.DATA_W(DW), .BASE_SHIFT(4), .TOT_W(TW), .HOLD_SAMPLES(HOLD)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: integers and flags following the behavioural rules sample by sample.
  int m_acc, m_cnt, m_hold, m_len;
  bit m_loaded, m_in, m_edge, m_tt, m_tv;
  int thr, hys, tmin;

  function automatic int lvl(input int off);
    return 100 + POL * off;
  endfunction

  task automatic set_cfg(input int t, input int h, input int m);
    thr = t; hys = h; tmin = m;
    bus.THRESHOLD = t[DW-1:0]; bus.HYSTERESIS = h[DW-1:0]; bus.TOT_MIN = m[TW-1:0];
  endtask

  task automatic model(input bit rst, input bit v, input int d, input bit en);
    int base, amp, rel;
    m_edge = 0; m_tt = 0; m_tv = 0;
    if (rst) begin
      m_acc = 0; m_loaded = 0; m_in = 0; m_cnt = 0; m_hold = 0; m_len = 0;
      return;
    end
    base = m_acc / 16;
    rel  = (thr > hys) ? thr - hys : 0;
    amp  = POL * (d - base);
    if (amp < 0) amp = 0;
    if (v && !m_loaded) begin
      m_acc = d * 16; m_loaded = 1;
    end else if (!en) begin
      if (v && !m_in && m_hold == 0) m_acc = m_acc + d - base;
      m_in = 0; m_hold = 0;
    end else if (v) begin
      if (m_in) begin
        if (amp >= rel) m_cnt = (m_cnt < TOT_MAX) ? m_cnt + 1 : TOT_MAX;
        else begin
          m_len = m_cnt; m_tv = 1; m_tt = (m_cnt >= tmin); m_in = 0; m_hold = HOLD;
        end
      end else if (m_hold > 0) m_hold--;
      else if (amp >= thr) begin
        m_edge = 1; m_in = 1; m_cnt = 1;
      end else m_acc = m_acc + d - base;
    end
  endtask

  task automatic drive(input bit rst, input bit v, input int d, input bit en);
    RESET_N = !rst; bus.ADC_VALID = v; bus.ADC_DATA = d[DW-1:0]; bus.ENABLE = en;
    @(posedge CLK); #1;
    model(rst, v, d, en);
  endtask

  function automatic logic [21:0] got_vec();
    return {bus.EDGE_TRIGGER, bus.TOT_TRIGGER, bus.TOT_VALID, bus.PULSE_ACTIVE, bus.TOT_LENGTH, bus.BASELINE};
  endfunction

  function automatic logic [21:0] exp_vec();
    int b;
    b = m_acc / 16;
    return {m_edge, m_tt, m_tv, m_in, m_len[TW-1:0], b[DW-1:0]};
  endfunction

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, lvl(0), 1);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 1);
    drive(1, 1, lvl(60), 1);
    checks++;
    if (got_vec() !== 22'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", got_vec());
    end
  endtask

  task automatic test_baseline();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, lvl(0), 1);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL baseline step %0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.BASELINE !== 12'd100 || bus.EDGE_TRIGGER !== 1'b0 || bus.TOT_TRIGGER !== 1'b0) begin
      errors++; $display("FAIL baseline_const: got base %0d edge %b tot %b want 100 0 0",
                         bus.BASELINE, bus.EDGE_TRIGGER, bus.TOT_TRIGGER);
    end
  endtask

  task automatic test_long_pulse();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, (i < 5) ? lvl(60) : lvl(0), 1);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL long_pulse step %0d: got %h want %h", i, got_vec(), exp_vec());
      end
      if (i == 0) begin
        checks++;
        if (bus.EDGE_TRIGGER !== 1'b1) begin
          errors++; $display("FAIL long_pulse_edge: got %b want 1", bus.EDGE_TRIGGER);
        end
      end
    end
    checks++;
    if (bus.TOT_LENGTH !== 6'd5 || bus.TOT_VALID !== 1'b1 || bus.TOT_TRIGGER !== 1'b1 || bus.BASELINE !== 12'd100) begin
      errors++; $display("FAIL long_pulse_end: got len %0d vld %b trig %b base %0d want 5 1 1 100",
                         bus.TOT_LENGTH, bus.TOT_VALID, bus.TOT_TRIGGER, bus.BASELINE);
    end
    settle(HOLD);
  endtask

  task automatic test_short_pulse();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, (i < 2) ? lvl(60) : lvl(0), 1);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL short_pulse step %0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.TOT_LENGTH !== 6'd2 || bus.TOT_VALID !== 1'b1 || bus.TOT_TRIGGER !== 1'b0) begin
      errors++; $display("FAIL short_pulse_end: got len %0d vld %b trig %b want 2 1 0",
                         bus.TOT_LENGTH, bus.TOT_VALID, bus.TOT_TRIGGER);
    end
    settle(HOLD);
  endtask

  task automatic test_hysteresis();
    int offs[4] = '{60, 45, 45, 30};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, lvl(offs[i]), 1);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL hysteresis step %0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.TOT_LENGTH !== 6'd3 || bus.TOT_VALID !== 1'b1) begin
      errors++; $display("FAIL hysteresis_end: got len %0d vld %b want 3 1", bus.TOT_LENGTH, bus.TOT_VALID);
    end
    settle(HOLD);
  endtask

  task automatic test_enable_drop();
    drive(0, 1, lvl(60), 1);
    drive(0, 1, lvl(60), 1);
    drive(0, 0, lvl(60), 0);
    checks++;
    if (got_vec() !== exp_vec() || bus.PULSE_ACTIVE !== 1'b0 || bus.TOT_VALID !== 1'b0) begin
      errors++; $display("FAIL enable_drop: got %h want %h", got_vec(), exp_vec());
    end
    drive(0, 1, lvl(60), 1);
    checks++;
    if (bus.EDGE_TRIGGER !== 1'b1 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL enable_refire: got %h want %h", got_vec(), exp_vec());
    end
    drive(0, 1, lvl(0), 1);
    settle(HOLD);
  endtask

  task automatic test_gaps();
    bit vs[7] = '{1, 0, 1, 0, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      drive(0, vs[i], (i < 6) ? lvl(60) : lvl(0), 1);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL gaps step %0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.TOT_LENGTH !== 6'd3 || bus.TOT_VALID !== 1'b1) begin
      errors++; $display("FAIL gaps_end: got len %0d vld %b want 3 1", bus.TOT_LENGTH, bus.TOT_VALID);
    end
    settle(HOLD);
  endtask

  task automatic test_tot_min_zero();
    set_cfg(50, 10, 0);
    drive(0, 1, lvl(60), 1);
    drive(0, 1, lvl(0), 1);
    checks++;
    if (bus.TOT_LENGTH !== 6'd1 || bus.TOT_TRIGGER !== 1'b1 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL tot_min_zero: got %h want %h", got_vec(), exp_vec());
    end
    set_cfg(50, 10, 3);
    settle(HOLD);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < TOT_MAX + 8; i++) drive(0, 1, lvl(60), 1);
    drive(0, 1, lvl(0), 1);
    checks++;
    if (bus.TOT_LENGTH !== 6'(TOT_MAX) || bus.TOT_TRIGGER !== 1'b1 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL saturation: got %h want %h", got_vec(), exp_vec());
    end
    settle(HOLD);
  endtask

  task automatic test_thr_zero();
    set_cfg(0, 0, 3);
    drive(0, 1, lvl(0), 1);
    checks++;
    if (bus.EDGE_TRIGGER !== 1'b1 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL thr_zero: got %h want %h", got_vec(), exp_vec());
    end
    settle(3);
    drive(0, 1, lvl(0), 0);
    checks++;
    if (bus.TOT_VALID !== 1'b0 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL thr_zero_abort: got %h want %h", got_vec(), exp_vec());
    end
    set_cfg(50, 10, 3);
  endtask

  task automatic test_reset_mid_pulse();
    drive(0, 1, lvl(60), 1);
    drive(0, 1, lvl(60), 1);
    drive(1, 1, lvl(60), 1);
    checks++;
    if (got_vec() !== 22'd0) begin
      errors++; $display("FAIL reset_mid_pulse: got %h want 0", got_vec());
    end
    drive(0, 1, lvl(0), 1);
    checks++;
    if (bus.BASELINE !== 12'd100 || bus.EDGE_TRIGGER !== 1'b0 || got_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_preload: got %h want %h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0)
        set_cfg(int'($urandom_range(10, 70)), int'($urandom_range(0, 80)), int'($urandom_range(0, 8)));
      drive(($urandom % 300) == 0, ($urandom % 4) != 0, lvl(int'($urandom_range(0, 110)) - 20),
            ($urandom % 40) != 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL random step %0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.ADC_VALID = 1'b0; bus.ADC_DATA = '0; bus.ENABLE = 1'b1;
    set_cfg(50, 10, 3);
    model(1, 0, 0, 1);
    test_reset();
    test_baseline();
    test_long_pulse();
    test_short_pulse();
    test_hysteresis();
    test_enable_drop();
    test_gaps();
    test_tot_min_zero();
    test_saturation();
    test_thr_zero();
    test_reset_mid_pulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pulse_discriminator.md
Name: pulse_discriminator

Overview:
- Front-end stage directly upstream of the trigger handler.
- Consumes the raw ADC sample stream and tracks a running baseline.
- Produces single-cycle EDGE_TRIGGER and TOT_TRIGGER pulses that feed the trigger handler's OR stage.
- Also reports the measured time-over-threshold per pulse for readout and diagnostics.

Parameters:
- DATA_W, 12, ADC sample width in bits.
- BASE_SHIFT, 4, baseline IIR coefficient; alpha = 1/2^BASE_SHIFT.
- TOT_W, 16, width of the ToT counter and the TOT_MIN / TOT_LENGTH ports.
- HOLD_SAMPLES, 8, valid samples with baseline frozen after each pulse ends.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  synchronous reset, active-low.
- ADC_DATA  in  DATA_W  unsigned ADC sample.
- ADC_VALID  in  1  ADC_DATA valid this cycle.
- ENABLE  in  1  discriminator armed.
- THRESHOLD  in  DATA_W  amplitude above baseline needed to fire.
- HYSTERESIS  in  DATA_W  margin below THRESHOLD needed to end a pulse.
- TOT_MIN  in  TOT_W  minimum pulse length, in samples, for TOT_TRIGGER.
- EDGE_TRIGGER  out  1  one-cycle pulse on a threshold crossing.
- TOT_TRIGGER  out  1  one-cycle pulse when a qualifying pulse ends.
- TOT_LENGTH  out  TOT_W  length of the last pulse, in samples.
- TOT_VALID  out  1  one-cycle strobe; TOT_LENGTH updated.
- BASELINE  out  DATA_W  current baseline estimate.
- PULSE_ACTIVE  out  1  high in state HIGH.

Behaviour:
- Reset (RESET_N low at a CLK edge):
  - state = IDLE, accumulator = 0, baseline_loaded = 0, ToT count = 0, hold count = 0.
  - All outputs = 0.
  - Reset mid-pulse aborts with no TOT_VALID.
- Baseline accumulator:
  - Width DATA_W+BASE_SHIFT, unsigned.
  - BASELINE = acc >> BASE_SHIFT.
  - First ADC_VALID after reset: acc <= ADC_DATA << BASE_SHIFT (preload); baseline_loaded <= 1. No trigger evaluation on that sample.
  - After preload, in IDLE only, each valid sample: acc <= acc + ADC_DATA - (acc >> BASE_SHIFT).
  - Frozen in HIGH and HOLD.
- Amplitude: amp = ADC_DATA - BASELINE, computed at DATA_W+1 bits signed. Negative values clamp to 0.
- Release level: rel = THRESHOLD - HYSTERESIS, saturating at 0.
- All decisions happen only on cycles with ADC_VALID=1 and baseline_loaded=1.
- Output latency: EDGE_TRIGGER, TOT_TRIGGER and TOT_VALID are registered and assert on the cycle after the deciding sample.
- States:
  - IDLE: if ENABLE and amp >= THRESHOLD, then EDGE_TRIGGER for 1 cycle, ToT count <= 1, go to HIGH.
  - HIGH: each valid sample with amp >= rel increments the ToT count, saturating at 2^TOT_W-1 (no wrap). A valid sample with amp < rel ends the pulse:
    - TOT_LENGTH <= count, TOT_VALID for 1 cycle.
    - TOT_TRIGGER for 1 cycle if count >= TOT_MIN.
    - Go to HOLD with hold count = HOLD_SAMPLES.
  - HOLD: decrement on each valid sample; go to IDLE when the count reaches 0. No triggers are produced in HOLD. If HOLD_SAMPLES = 0, go straight to IDLE.
- ENABLE low:
  - Forces IDLE on the next cycle; an in-progress pulse is discarded (no TOT_VALID, no TOT_TRIGGER).
  - Baseline keeps tracking.
- TOT_MIN = 0: every completed pulse fires TOT_TRIGGER.
- THRESHOLD = 0: every valid sample in IDLE fires.
- Gaps in ADC_VALID do not advance any counter.
- TOT_LENGTH holds its value until the next completed pulse.

Optional Feature:
- Macro: NEG_POLARITY_EN.
- Defined: amp = BASELINE - ADC_DATA, clamped at 0, for negative-going detector pulses. The baseline update is unchanged.
- Undefined: positive polarity as above.

Test Plan:
- Reset, then a constant 100 stream: first sample preloads, BASELINE = 100 thereafter; EDGE_TRIGGER and TOT_TRIGGER stay 0.
- Baseline 100, THRESHOLD=50, HYSTERESIS=10, TOT_MIN=3; samples 160×5 then 100: EDGE_TRIGGER one cycle after the first 160; TOT_LENGTH=5, TOT_VALID=1, TOT_TRIGGER=1 one cycle after the 100 sample; BASELINE stays 100.
- Same setup, samples 160×2 then 100: TOT_VALID=1, TOT_LENGTH=2, TOT_TRIGGER=0.
- Hysteresis check: samples 160, 145, 145, 130: the pulse ends only on 130 (amp 30 < 40); TOT_LENGTH=3.
- ENABLE dropped after 2 samples of 160: no TOT_VALID; after HOLD is skipped, a new 160 re-fires EDGE_TRIGGER once ENABLE=1.
- RESET_N low mid-pulse: all outputs 0 the next cycle; the next valid sample preloads the baseline.
